// File: rtl/dac_i2s_serializer_pkg.sv
// dac_i2s_serializer_pkg: shared sample width, stereo frame type and serializer FSM states.
package dac_i2s_serializer_pkg;

   localparam int SAMPLE_WIDTH_DEF = 16;

   typedef struct packed {
      logic signed [SAMPLE_WIDTH_DEF-1:0] left;
      logic signed [SAMPLE_WIDTH_DEF-1:0] right;
   } stereo_frame_t;

   typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} dac_state_e;

endpackage

// File: rtl/dac_i2s_serializer_fifo.sv
// sample_fifo: frame-wide synchronous FIFO; ready is registered so a full FIFO refuses a push
// even when a pop happens in the same cycle.
module sample_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             ready_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ready_q, push, pop;

   assign push    = push_i & ready_q;
   assign pop     = pop_i & ~empty_o;
   assign empty_o = cnt_q == '0;
   assign ready_o = ready_q;
   assign data_o  = mem_q[rd_q];
   assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         wr_q    <= push ? wr_q + AW'(1) : wr_q;
         rd_q    <= pop ? rd_q + AW'(1) : rd_q;
         cnt_q   <= cnt_d;
         ready_q <= cnt_d != CW'(DEPTH);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/dac_i2s_serializer.sv
// dac_i2s_serializer: buffers stereo frames and shifts them out as an I2S slave, oversampling BCLK/LRCK.
// Define DAC_UNDERRUN_HOLD_EN to replay the last frame on underrun instead of outputting silence.
module dac_i2s_serializer
   import dac_i2s_serializer_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic [SAMPLE_WIDTH-1:0] leftSampleIn,
   input  logic [SAMPLE_WIDTH-1:0] rightSampleIn,
   input  logic                    sampleValid,
   output logic                    sampleReady,
   input  logic                    AUD_BCLK,
   input  logic                    AUD_DACLRCK,
   output logic                    AUD_DACDAT,
   output logic                    underrun,
   input  logic                    clearUnderrun
);
   localparam int FW = 2 * SAMPLE_WIDTH;
   localparam int CW = $clog2(SAMPLE_WIDTH + 1);

   logic [1:0]              bclk_sync_q, lrck_sync_q;
   logic                    bclk_prev_q, lrck_prev_q;
   dac_state_e              state_q;
   logic [SAMPLE_WIDTH-1:0] shift_q, right_hold_q;
   logic [CW-1:0]           bit_cnt_q;
   logic                    dacdat_q, underrun_q;
   logic [FW-1:0]           fifo_rd, hold_frame, frame_d;
   logic                    fifo_empty, bclk_fall, lrck_now, boundary, left_start;

   assign bclk_fall  = bclk_prev_q & ~bclk_sync_q[1];
   assign lrck_now   = lrck_sync_q[1];
   assign boundary   = bclk_fall & (lrck_now != lrck_prev_q);
   assign left_start = boundary & ~lrck_now;
   assign frame_d    = fifo_empty ? hold_frame : fifo_rd;
   assign AUD_DACDAT = dacdat_q;
   assign underrun   = underrun_q;

   sample_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .push_i (sampleValid),
      .pop_i  (left_start),
      .data_i ({leftSampleIn, rightSampleIn}),
      .data_o (fifo_rd),
      .ready_o(sampleReady),
      .empty_o(fifo_empty)
   );

`ifdef DAC_UNDERRUN_HOLD_EN
   logic [FW-1:0] last_q;
   assign hold_frame = last_q;
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) last_q <= '0;
      else if (left_start && !fifo_empty) last_q <= fifo_rd;
   end
`else
   assign hold_frame = '0;
`endif

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         bclk_sync_q  <= '0;
         lrck_sync_q  <= '0;
         bclk_prev_q  <= 1'b0;
         lrck_prev_q  <= 1'b0;
         state_q      <= ALIGN;
         shift_q      <= '0;
         right_hold_q <= '0;
         bit_cnt_q    <= '0;
         dacdat_q     <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
         lrck_sync_q <= {lrck_sync_q[0], AUD_DACLRCK};
         bclk_prev_q <= bclk_sync_q[1];
         if (bclk_fall) lrck_prev_q <= lrck_now;
         if (clearUnderrun) underrun_q <= 1'b0;
         if (left_start && fifo_empty) underrun_q <= 1'b1;
         if (bclk_fall) begin
            if (boundary) begin
               // The first BCLK of every slot carries the I2S one-bit delay.
               dacdat_q  <= 1'b0;
               bit_cnt_q <= '0;
               if (!lrck_now) begin
                  state_q      <= LEFT;
                  shift_q      <= frame_d[FW-1:SAMPLE_WIDTH];
                  right_hold_q <= frame_d[SAMPLE_WIDTH-1:0];
               end else if (state_q != ALIGN) begin
                  state_q <= RIGHT;
                  shift_q <= right_hold_q;
               end
            end else if (state_q != ALIGN && bit_cnt_q < CW'(SAMPLE_WIDTH)) begin
               dacdat_q  <= shift_q[SAMPLE_WIDTH-1];
               shift_q   <= {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
               bit_cnt_q <= bit_cnt_q + CW'(1);
            end else begin
               dacdat_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dac_i2s_serializer.sv
// tb_dac_i2s_serializer: codec-master model driving BCLK/LRCK, frame-queue reference and slot-level checks.
// Honours DAC_UNDERRUN_HOLD_EN the same way as the design.
module tb_dac_i2s_serializer;

   logic        clk = 1'b0;
   logic        RESET_N = 1'b0;
   logic [15:0] left_in = '0, right_in = '0;
   logic        valid = 1'b0, clear_unr = 1'b0;
   logic        bclk = 1'b1, lrck = 1'b0;
   logic        sampleReady, AUD_DACDAT, underrun;

   int n_cmp = 0, n_err = 0;

   dac_i2s_serializer dut (
      .CLOCK_50     (clk),
      .RESET_N      (RESET_N),
      .leftSampleIn (left_in),
      .rightSampleIn(right_in),
      .sampleValid  (valid),
      .sampleReady  (sampleReady),
      .AUD_BCLK     (bclk),
      .AUD_DACLRCK  (lrck),
      .AUD_DACDAT   (AUD_DACDAT),
      .underrun     (underrun),
      .clearUnderrun(clear_unr)
   );

   always #10 clk = ~clk;

   logic [31:0] q[$];
   logic [31:0] last_fr = '0;
   logic [15:0] cur_r = '0;
   bit          aligned = 0, exp_unr = 0;
   bit          codec_en = 0, stop_req = 0, running = 0, slot_dirty = 1;
   int          slot_len = 32, bit_idx = 32, slots_done = 0;
   logic [63:0] got = '0, exp_bits = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Bits the codec should capture in a slot: delay bit, word MSB first, then padding zeros.
   function automatic logic [63:0] slot_bits(input logic [15:0] w, input int len);
      logic [63:0] b = '0;
      for (int i = 0; i < 16; i++) if (i + 1 < len) b[i+1] = w[15-i];
      return b;
   endfunction

   initial begin : codec
      logic [31:0] fr;
      forever begin
         if (!codec_en || (stop_req && bit_idx >= slot_len)) begin
            running = 0;
            @(posedge clk);
         end else begin
            running = 1;
            repeat (8) @(posedge clk);
            #2 bclk = 1'b0;
            if (bit_idx >= slot_len) begin
               lrck = ~lrck;
               bit_idx = 0;
               got = '0;
               slot_dirty = !RESET_N;
               if (!lrck) begin
                  if (RESET_N) begin
                     aligned = 1;
                     if (q.size() == 0) begin
                        exp_unr = 1;
`ifdef DAC_UNDERRUN_HOLD_EN
                        fr = last_fr;
`else
                        fr = '0;
`endif
                     end else begin
                        fr = q.pop_front();
                        last_fr = fr;
                     end
                     exp_bits = slot_bits(fr[31:16], slot_len);
                     cur_r = fr[15:0];
                  end
               end else begin
                  exp_bits = aligned ? slot_bits(cur_r, slot_len) : '0;
               end
            end
            repeat (8) @(posedge clk);
            #2 bclk = 1'b1;
            if (!RESET_N) slot_dirty = 1;
            got[bit_idx] = AUD_DACDAT;
            bit_idx++;
            if (bit_idx == slot_len) begin
               if (!slot_dirty) begin
                  chk(lrck ? "right_slot" : "left_slot", got, exp_bits);
                  chk("underrun_slot", 64'(underrun), 64'(exp_unr));
               end
               slots_done++;
            end
         end
      end
   end

   task automatic wait_slots(input int n);
      int t = 0;
      while (slots_done < n && t < 40000) begin
         @(posedge clk);
         t++;
      end
      if (slots_done < n) chk("wait_slots_timeout", 64'(slots_done), 64'(n));
   endtask

   task automatic wait_pos(input logic l, input int idx);
      int t = 0;
      while (!(lrck == l && bit_idx == idx) && t < 40000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 40000) chk("wait_pos_timeout", 64'(bit_idx), 64'(idx));
   endtask

   task automatic stop_codec();
      int t = 0;
      stop_req = 1;
      @(posedge clk);
      while (running && t < 40000) begin
         @(posedge clk);
         t++;
      end
      if (running) chk("stop_timeout", 64'(running), 64'(0));
      codec_en = 0;
      stop_req = 0;
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r, input bit exp_rdy);
      @(negedge clk);
      chk("sampleReady", 64'(sampleReady), 64'(exp_rdy));
      left_in = l;
      right_in = r;
      valid = 1'b1;
      if (exp_rdy) q.push_back({l, r});
      @(negedge clk);
      valid = 1'b0;
   endtask

   typedef struct {
      bit          v;
      logic [15:0] l, r;
      bit          exp_ready;
   } vec_t;
   vec_t tbl[7];

   initial begin
      tbl[0] = '{0, 16'h0000, 16'h0000, 1};
      tbl[1] = '{1, 16'hA5C3, 16'h0F0F, 1};
      for (int i = 2; i < 5; i++) tbl[i] = '{1, 16'($urandom), 16'($urandom), 1};
      tbl[5] = '{1, 16'hDEAD, 16'hBEEF, 0};
      tbl[6] = '{0, 16'h0000, 16'h0000, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_dacdat", 64'(AUD_DACDAT), 64'(0));
      chk("rst_ready", 64'(sampleReady), 64'(0));
      chk("rst_underrun", 64'(underrun), 64'(0));
      @(negedge clk) RESET_N = 1'b1;
      repeat (3) @(posedge clk);

      // Codec clocks stopped: fill the FIFO, fifth frame must be refused.
      foreach (tbl[i]) begin
         @(negedge clk);
         chk("tbl_ready", 64'(sampleReady), 64'(tbl[i].exp_ready));
         left_in = tbl[i].l;
         right_in = tbl[i].r;
         valid = tbl[i].v;
         if (tbl[i].v && tbl[i].exp_ready) q.push_back({tbl[i].l, tbl[i].r});
      end
      @(negedge clk) valid = 1'b0;

      codec_en = 1;
      wait_slots(1);
      #1 chk("ready_before_left", 64'(sampleReady), 64'(0));
      repeat (4) @(posedge bclk);
      #1 chk("ready_after_left", 64'(sampleReady), 64'(1));
      wait_slots(12);

      // Clear underrun mid right slot with FIFO empty; it must re-set at the next left boundary.
      repeat (3) @(posedge bclk);
      @(negedge clk) clear_unr = 1'b1;
      @(negedge clk) clear_unr = 1'b0;
      exp_unr = 0;
      #1 chk("underrun_cleared", 64'(underrun), 64'(0));
      wait_slots(14);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(1, 12)) @(posedge bclk);
         if ($urandom_range(0, 2) != 0) push(16'($urandom), 16'($urandom), q.size() < 4);
      end
      wait_slots(slots_done + 12);

      stop_codec();
      slot_len = 8;
      push(16'hFFFF, 16'h1234, q.size() < 4);
      codec_en = 1;
      wait_slots(slots_done + 12);
      stop_codec();
      slot_len = 32;
      codec_en = 1;
      wait_slots(slots_done + 2);

      // Reset asynchronously mid left word, release inside a right slot.
      wait_pos(1'b0, 8);
      #5 RESET_N = 1'b0;
      q.delete();
      aligned = 0;
      exp_unr = 0;
      last_fr = '0;
      #1;
      chk("midrst_dacdat", 64'(AUD_DACDAT), 64'(0));
      chk("midrst_ready", 64'(sampleReady), 64'(0));
      chk("midrst_underrun", 64'(underrun), 64'(0));
      wait_pos(1'b1, 10);
      @(negedge clk) RESET_N = 1'b1;
      @(posedge bclk);
      push(16'h1357, 16'h2468, 1);
      wait_slots(slots_done + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
